// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one 1-bit slice (two half adders + OR) reused LSB first.
// Latency: start accepted at edge E, done high the cycle after edge E+WIDTH.
// Backpressure: none; start is ignored outside IDLE and nothing is queued.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, carry_nxt;
  logic             p, g1, s, g2;

  // The single shared slice: a_sh[0] + b_sh[0] + carry.
  always_comb begin
    p         = a_sh[0] ^ b_sh[0];
    g1        = a_sh[0] & b_sh[0];
    s         = p ^ carry;
    g2        = p & carry;
    carry_nxt = g1 | g2;
    r_nxt     = WIDTH'({s, r_sh} >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= c_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= carry_nxt;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_nxt;
          if (cnt == LAST) begin
            // Result only becomes visible here, so partial sums never leak out.
            sum   <= r_nxt;
            c_out <= carry_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out;
  logic [W-1:0] sum;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0, b1 = '0, sum1;
  logic         cin1 = 1'b0;
  logic         busy1, done1, cout1;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then follow the operation cycle by cycle through done.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] es, input logic ec);
    a = av; b = bv; c_in = cv; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_nodone"}, done, 0);
      step();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, c_out, ec);
    step();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_sum_hold"}, sum, es);
    chk({tag, "_cout_hold"}, c_out, ec);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_sum", sum, 0);
    end

    run_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("chain1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("chain2", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_op("cin_mix", 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1);
    run_op("plain", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0);

    // Operand change and start during RUN must be ignored.
    a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 8'hFF; c_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("ign_done", done, 1);
    chk("ign_sum", sum, 8'h30);
    chk("ign_cout", c_out, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ign_no_second_busy", busy, 0);
      chk("ign_no_second_done", done, 0);
    end

    // Reset during the 4th RUN cycle aborts with no done.
    a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("abort_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", c_out, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    run_op("fresh", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // rst wins over start on the same edge.
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("rst_vs_start", busy, 0);
    step();
    chk("rst_vs_start_idle", busy, 0);

    // Back-to-back with start held: one op every W+2 cycles.
    a = 8'h80; b = 8'h80; c_in = 1'b0; start = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < W; i++) begin
        chk("b2b_nodone", done, 0);
        step();
      end
      chk("b2b_done", done, 1);
      chk("b2b_sum", sum, 8'h00);
      chk("b2b_cout", c_out, 1);
      step();
      chk("b2b_gap", done, 0);
      chk("b2b_gap_busy", busy, 0);
      step();
      chk("b2b_restart", busy, 1);
    end
    start = 1'b0;
    for (int i = 0; i < W + 4; i++) step();
    chk("b2b_drained", busy, 0);

    // WIDTH=1 instance: completion on the first RUN edge.
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("w1_busy", busy1, 1);
    chk("w1_nodone", done1, 0);
    step();
    chk("w1_done", done1, 1);
    chk("w1_sum", sum1, 1);
    chk("w1_cout", cout1, 1);
    chk("w1_busy_off", busy1, 0);
    step();
    chk("w1_pulse", done1, 0);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    chk("w1b_done", done1, 1);
    chk("w1b_sum", sum1, 1);
    chk("w1b_cout", cout1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that performs a WIDTH-bit addition by reusing one 1-bit add slice (two half adders plus an OR for carry) over WIDTH clock cycles, LSB first.
- Captures operands on a start request and holds the carry in a flop between bit steps.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Serves as the area-minimal adder controller in the combinational/sequential basics set, and is the first block that sequences the half-adder datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- c_in  input  1  carry-in; captured when start is accepted
- busy  output  1  high while the FSM is in RUN
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result of a+b+c_in (low WIDTH bits)
- c_out  output  1  registered carry-out of the addition

Behaviour:
- Interface: one clock domain (clk); rst is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset: state=IDLE; busy=0, done=0, sum=0, c_out=0; internal shift registers, carry flop and bit counter are all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge, capture a and b into shift registers and c_in into the carry flop.
  - Clear bit counter cnt to 0 and go to RUN.
  - Otherwise remain in IDLE.
- RUN, every edge:
  - Slice inputs: x=a_sh[0], y=b_sh[0], carry.
  - Half adder 1: p = x^y, g1 = x&y.
  - Half adder 2: s = p^carry, g2 = p&carry.
  - Update carry <= g1|g2.
  - Shift a_sh and b_sh right by 1; shift s into the MSB of the result shift register.
  - cnt <= cnt+1.
  - On the edge where cnt == WIDTH-1: load sum from the result shift register (including this step's s), load c_out from the new carry, and go to DONE.
- DONE: done=1 for exactly this one cycle, then IDLE on the next edge unconditionally.
- Output encoding:
  - busy = (state==RUN).
  - done = (state==DONE), registered.
  - sum and c_out change only on the completion edge; they hold the last result until the next completion or reset. Partial results are never visible on sum.
- Latency:
  - With start sampled at edge E, done is high during the cycle following edge E+WIDTH.
  - Back-to-back throughput is one operation per WIDTH+2 cycles (start held high is re-accepted in IDLE).
- Arithmetic:
  - Unsigned.
  - {c_out,sum} == a+b+c_in for the captured values.
  - Overflow appears only in c_out; there is no wrap flag.
- Boundary conditions:
  - start while busy=1 or done=1 is ignored; no queuing.
  - Changes on a, b or c_in after capture do not affect the operation in progress.
  - WIDTH=1: RUN lasts one cycle, and the completion edge is the first RUN edge.
  - cnt width is clog2(WIDTH), minimum 1 bit; cnt never exceeds WIDTH-1.
  - rst asserted in any state, including mid-RUN: next state is IDLE and every output returns to its reset value; the aborted operation produces no done.
  - rst and start high on the same edge: rst wins and start is not accepted.

Test Plan:
- Reset check: hold rst for 2 cycles -> busy=0, done=0, sum=8'h00, c_out=0. Keep start=0 for 5 cycles -> outputs unchanged.
- Basic add: a=8'h5A, b=8'h3C, c_in=0, start pulsed at edge E -> busy=1 for 8 cycles; done=1 for exactly one cycle after edge E+8; sum=8'h96, c_out=0; values held afterwards.
- Carry chain: a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1. Also a=8'hFF, b=8'h00, c_in=1 -> sum=8'h00, c_out=1.
- Ignored inputs: during RUN of a=8'h10, b=8'h20, change a to 8'hFF and pulse start -> result sum=8'h30, c_out=0; exactly one done pulse; no second operation starts.
- Reset mid-operation: assert rst on the 4th RUN cycle -> next cycle busy=0, sum=0; no done pulse. A fresh start with a=8'h01, b=8'h01 -> sum=8'h02.
- Back-to-back: hold start=1 with a=8'h80, b=8'h80 -> done pulses every 10 cycles, each with sum=8'h00, c_out=1. Repeat with WIDTH=1: a=1, b=1, c_in=1 -> sum=1, c_out=1, done 1 cycle after start edge +1.
